// File: rtl/valve_pulse_driver.sv
// valve_pulse_driver: solenoid drive with min-on/min-off/max-on timing; actuation counter under VPD_ACT_COUNT_EN
module valve_pulse_driver #(
    parameter int ON_MIN  = 16,
    parameter int OFF_MIN = 8,
    parameter int ON_MAX  = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             sm_clock,
    input  logic             reset,
    input  logic             req_in,
    input  logic             fault_clr,
    output logic             valve_out,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] act_count
);
    typedef enum logic [2:0] {IDLE, OPEN_MIN, OPEN, CLOSE_MIN, FAULT} state_t;
    localparam logic [15:0] ON_MIN_T  = 16'(ON_MIN - 1);
    localparam logic [15:0] OFF_MIN_T = 16'(OFF_MIN - 1);
    localparam logic [15:0] ON_MAX_T  = 16'(ON_MAX - 1);
    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_timer;
    logic        w_keep;
    assign w_keep = (w_next == r_state) || (r_state == OPEN_MIN && w_next == OPEN);
    // next-state selection; unused encodings fall back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (req_in) w_next = OPEN_MIN;
            OPEN_MIN:  if (r_timer == ON_MIN_T) w_next = req_in ? OPEN : CLOSE_MIN;
            OPEN:      w_next = !req_in ? CLOSE_MIN : (r_timer == ON_MAX_T) ? FAULT : OPEN;
            CLOSE_MIN: if (r_timer == OFF_MIN_T) w_next = IDLE;
            FAULT:     if (fault_clr && !req_in) w_next = CLOSE_MIN;
            default:   w_next = IDLE;
        endcase
    end
    // state, shared timer and registered outputs decoded from the next state
    always_ff @(posedge sm_clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            valve_out <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timer   <= w_keep ? r_timer + 16'd1 : 16'd0;
            valve_out <= (w_next == OPEN_MIN) || (w_next == OPEN);
            busy      <= w_next != IDLE;
            fault     <= w_next == FAULT;
        end
    end
`ifdef VPD_ACT_COUNT_EN
    logic [CNT_W-1:0] r_count;
    // saturating count of IDLE to OPEN_MIN transitions
    always_ff @(posedge sm_clock) begin
        if (reset) r_count <= '0;
        else if (r_state == IDLE && req_in && !(&r_count)) r_count <= r_count + 1'b1;
    end
    assign act_count = r_count;
`else
    assign act_count = '0;
`endif
endmodule

// File: tb/tb_valve_pulse_driver.sv
// tb_valve_pulse_driver: directed scoreboard bench for valve_pulse_driver
module tb_valve_pulse_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       clr = 1'b0;
    logic       valve;
    logic       busy;
    logic       fault;
    logic [3:0] cnt;
    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
`ifdef VPD_ACT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    valve_pulse_driver #(.ON_MIN(4), .OFF_MIN(3), .ON_MAX(10), .CNT_W(4)) dut (
        .sm_clock(clk), .reset(rst), .req_in(req), .fault_clr(clr),
        .valve_out(valve), .busy(busy), .fault(fault), .act_count(cnt)
    );

    // drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input string tag, input logic r, input logic rq, input logic c,
                        input logic v, input logic b, input logic f, input int n);
        @(negedge clk);
        rst = r;
        req = rq;
        clr = c;
        q.push_back('{tag, {v, b, f, CNT_EN ? 4'(n) : 4'd0}});
    endtask

    task automatic steps(input int k, input string tag, input logic rq, input logic c,
                         input logic v, input logic b, input logic f, input int n);
        for (int i = 0; i < k; i++) step(tag, 1'b0, rq, c, v, b, f, n);
    endtask

    // one-cycle request: 4 open, 3 recovery, then idle
    task automatic pulse(input string tag, input int n);
        step(tag, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, n);
        steps(3, tag, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, n);
        steps(3, tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n);
    endtask

    task automatic do_reset();
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({valve, busy, fault, cnt} !== e.exp) begin
                errors++;
                $display("FAIL %s: got v/b/f/cnt=%b want %b at %0t", e.tag, {valve, busy, fault, cnt}, e.exp, $time);
            end
        end
    end

    initial begin
        step("rst_hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step("rst_hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step("rst_release", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        steps(3, "rst_open", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        steps(3, "rst_close", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        step("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        do_reset();
        pulse("short", 1);
        step("clr_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);

        do_reset();
        steps(7, "long_open", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        steps(3, "long_close", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        step("long_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        do_reset();
        steps(10, "to_open", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        steps(10, "to_fault", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        step("to_clr_req", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        step("to_noclr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        step("to_clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        steps(2, "to_close", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        step("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        do_reset();
        step("rereq_open", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        steps(3, "rereq_open", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        steps(2, "rereq_close", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        step("rereq_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        step("rereq_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step("rereq_reopen", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        steps(3, "rereq_open2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        steps(3, "rereq_close2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        step("rereq_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        do_reset();
        steps(10, "race_open", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        step("race_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        steps(2, "race_close", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        step("race_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        do_reset();
        steps(2, "midrst_open", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        step("midrst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step("midrst_norecov", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        do_reset();
        for (int i = 1; i <= 20; i++) pulse("sat", i > 15 ? 15 : i);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
